// File: rtl/top_unit_pkg.sv
// Shared types and constants for the byte-capture display unit:
// control FSM states and the active-low seven-segment lookup table.
package top_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}, indexed by hex digit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/top_unit_if.sv
// Capture handshake between the control FSM (master) and the datapath (slave).
interface top_unit_if;

    logic loaddata;
    logic inputdata_ready;

    modport master (
        output loaddata,
        input  inputdata_ready
    );

    modport slave (
        input  loaddata,
        output inputdata_ready
    );

endinterface

// File: rtl/top_unit_control.sv
// Control FSM: opens the capture window in S_LOAD and closes it for one
// cycle after each completed capture.
module controlunit
    import top_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    top_unit_if.master hs
);

    state_t state;

    // loaddata is registered alongside the state so it is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            hs.loaddata <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state       <= S_LOAD;
                    hs.loaddata <= 1'b1;
                end
                S_LOAD: begin
                    if (hs.inputdata_ready) begin
                        state       <= S_DONE;
                        hs.loaddata <= 1'b0;
                    end
                end
                S_DONE: begin
                    state       <= S_LOAD;
                    hs.loaddata <= 1'b1;
                end
                default: begin
                    state       <= S_IDLE;
                    hs.loaddata <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/top_unit_datapath.sv
// Datapath: synchronizes the enter button, detects its rising edge, shifts
// captured bytes through cur/prev and decodes both onto four displays.
module datapathunit
    import top_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic [7:0] inputdata,
    top_unit_if.slave  hs,
    output logic [6:0] disp3,
    output logic [6:0] disp2,
    output logic [6:0] disp1,
    output logic [6:0] disp0
);

    logic       sync1;
    logic       sync2;
    logic       enterhist;
    logic       enterpulse;
    logic       capture;
    logic [7:0] prev;
    logic [7:0] cur;

    assign enterpulse = sync2 & ~enterhist;
    assign capture    = enterpulse & hs.loaddata;

    // Clearing the edge history on reset makes a button held through reset
    // look like a fresh press once reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1              <= 1'b0;
            sync2              <= 1'b0;
            enterhist          <= 1'b0;
            prev               <= 8'h00;
            cur                <= 8'h00;
            hs.inputdata_ready <= 1'b0;
        end else begin
            sync1              <= enter;
            sync2              <= sync1;
            enterhist          <= sync2;
            hs.inputdata_ready <= capture;
            if (capture) begin
                prev <= cur;
                cur  <= inputdata;
            end
        end
    end

    hex7seg u_seg3 (.digit(prev[7:4]), .seg(disp3));
    hex7seg u_seg2 (.digit(prev[3:0]), .seg(disp2));
    hex7seg u_seg1 (.digit(cur[7:4]),  .seg(disp1));
    hex7seg u_seg0 (.digit(cur[3:0]),  .seg(disp0));

endmodule

// File: rtl/top_unit_hex7seg.sv
// One hex digit to one active-low seven-segment pattern.
module hex7seg
    import top_unit_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(digit);

endmodule

// File: rtl/top_unit.sv
// Top level: button polarity glue plus one control FSM and one datapath
// joined by the capture handshake.
module top_unit
    import top_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       nenter,
    input  logic [7:0] inputdata,
    output logic [6:0] disp3,
    output logic [6:0] disp2,
    output logic [6:0] disp1,
    output logic [6:0] disp0
);

    logic enter;

    assign enter = ~nenter;

    top_unit_if hs ();

    controlunit u_ctrl (
        .clk   (clk),
        .reset (reset),
        .hs    (hs)
    );

    datapathunit u_dp (
        .clk       (clk),
        .reset     (reset),
        .enter     (enter),
        .inputdata (inputdata),
        .hs        (hs),
        .disp3     (disp3),
        .disp2     (disp2),
        .disp1     (disp1),
        .disp0     (disp0)
    );

endmodule

// File: tb/tb_top_unit.sv
// Self-checking bench for top_unit: table of presses with chained prev/cur
// expectations, a scoreboard popped on each ready pulse, and reset corner cases.
module tb_top_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       nenter;
    logic [7:0] inputdata;
    logic [6:0] disp3, disp2, disp1, disp0;
    logic [27:0] dispall;

    int checks = 0;
    int errors = 0;
    int readycount = 0;

    logic [27:0] expq [$];
    logic [7:0]  modelcur;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [27:0] ALLZERO = {7'h40, 7'h40, 7'h40, 7'h40};

    typedef struct {
        logic [7:0]  data;
        logic [27:0] expdisp;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    top_unit dut (
        .clk       (clk),
        .reset     (reset),
        .nenter    (nenter),
        .inputdata (inputdata),
        .disp3     (disp3),
        .disp2     (disp2),
        .disp1     (disp1),
        .disp0     (disp0)
    );

    top_unit_if mon ();
    assign mon.loaddata        = dut.hs.loaddata;
    assign mon.inputdata_ready = dut.hs.inputdata_ready;
    assign dispall = {disp3, disp2, disp1, disp0};

    always @(negedge clk) begin
        if (mon.inputdata_ready === 1'b1) readycount <= readycount + 1;
    end

    function automatic logic [27:0] expfor(input logic [7:0] p, input logic [7:0] c);
        return {SEG[p[7:4]], SEG[p[3:0]], SEG[c[7:4]], SEG[c[3:0]]};
    endfunction

    task automatic checkOutput(input string name, input logic [27:0] actual, input logic [27:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // One press held for 'hold' edges; the expected displays wait in the
    // scoreboard until the DUT signals the capture.
    task automatic applyStimulus(input logic [7:0] d, input int hold, input logic [27:0] expected);
        int  start;
        bit  got;
        expq.push_back(expected);
        start = readycount;
        got   = 1'b0;
        @(posedge clk);
        #1;
        inputdata = d;
        nenter    = 1'b0;
        for (int c = 0; c < hold + 12; c++) begin
            @(negedge clk);
            if (c == hold) nenter = 1'b1;
            if (mon.inputdata_ready === 1'b1 && !got) begin
                got = 1'b1;
                checkOutput("capture_disp", dispall, expq.pop_front());
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout data=%h actual=none expected=one pulse", d);
            void'(expq.pop_front());
        end
        @(negedge clk);
        checkOutput("ready_pulses", 28'(readycount - start), 28'd1);
    endtask

    initial begin
        int         start;
        bit         got;
        logic [7:0] p;

        reset     = 1'b1;
        nenter    = 1'b1;
        inputdata = 8'h00;
        modelcur  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_disp", dispall, ALLZERO);
        checkOutput("reset_loaddata", 28'(mon.loaddata), 28'd0);
        checkOutput("reset_ready", 28'(mon.inputdata_ready), 28'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("fsm_load", 28'(mon.loaddata), 28'd1);

        // First press: nothing before the third edge, capture on it
        start     = readycount;
        inputdata = 8'hA5;
        nenter    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre_capture", dispall, ALLZERO);
        @(posedge clk);
        @(negedge clk);
        checkOutput("third_edge", dispall, {7'h40, 7'h40, 7'h08, 7'h12});
        @(posedge clk);
        @(posedge clk);
        #1 nenter = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("a5_pulses", 28'(readycount - start), 28'd1);
        checkOutput("a5_disp", dispall, {7'h40, 7'h40, 7'h08, 7'h12});
        modelcur = 8'hA5;

        // Table of presses, each expectation chained from the byte before
        vecs[0].data = 8'h3C;
        vecs[1].data = 8'h00;
        vecs[2].data = 8'hFF;
        vecs[3].data = 8'h96;
        vecs[4].data = 8'hE1;
        vecs[5].data = 8'h7B;
        vecs[6].data = 8'h48;
        p = 8'hA5;
        for (int i = 0; i < 7; i++) begin
            vecs[i].expdisp = expfor(p, vecs[i].data);
            p = vecs[i].data;
        end
        checkOutput("vec0_const", vecs[0].expdisp, {7'h08, 7'h12, 7'h30, 7'h46});
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].data, 3, vecs[i].expdisp);
            modelcur = vecs[i].data;
        end

        // Long hold: exactly one capture
        applyStimulus(8'hC3, 50, expfor(modelcur, 8'hC3));
        modelcur = 8'hC3;

        // Reset lands on the capture edge: capture is lost
        start = readycount;
        @(posedge clk);
        #1;
        inputdata = 8'h77;
        nenter    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        nenter = 1'b1;
        @(negedge clk);
        checkOutput("reset_capture_disp", dispall, ALLZERO);
        checkOutput("reset_capture_ready", 28'(mon.inputdata_ready), 28'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("reset_capture_pulses", 28'(readycount - start), 28'd0);
        checkOutput("reset_capture_after", dispall, ALLZERO);
        modelcur = 8'h00;

        // Button held across reset release counts as one new press
        start     = readycount;
        inputdata = 8'h5A;
        nenter    = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (mon.inputdata_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL held_reset_timeout actual=none expected=one pulse");
        end
        checkOutput("held_reset_disp", dispall, {7'h40, 7'h40, 7'h12, 7'h08});
        repeat (4) @(negedge clk);
        nenter = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("held_reset_pulses", 28'(readycount - start), 28'd1);
        modelcur = 8'h5A;

        // Full byte sweep
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'(i), 2, expfor(modelcur, 8'(i)));
            modelcur = 8'(i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
